// File: rtl/spot_allocator.sv
// ---------------------------------------------------------------------------
// spot_allocator : parking lot entry/exit controller, drives occupancy writes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spot_allocator #(
  parameter int unsigned GATE_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       car_in,
  input  logic       car_out,
  input  logic [1:0] out_spot,
  input  logic [3:0] E,
  output logic       En,
  output logic       make_entry,
  output logic [1:0] sel,
  output logic [1:0] assigned,
  output logic       grant,
  output logic       reject,
  output logic       error,
  output logic       gate_open,
  output logic       full,
  output logic [2:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GATE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES);

  state_t     state_q, state_d;
  logic [7:0] gate_cnt_q, gate_cnt_d;
  logic       src_in_q, src_in_d;
  logic       en_q, en_d;
  logic       make_entry_q, make_entry_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] assigned_q, assigned_d;
  logic       grant_q, grant_d;
  logic       reject_q, reject_d;
  logic       error_q, error_d;
  logic       gate_open_q, gate_open_d;
  logic       full_q, full_d;
  logic [2:0] count_q, count_d;
  logic [1:0] free_idx;

  always_comb begin
    casez (E)
      4'b???1: free_idx = 2'd0;
      4'b??10: free_idx = 2'd1;
      4'b?100: free_idx = 2'd2;
      default: free_idx = 2'd3;
    endcase
  end

  // Every output is registered on the accepting edge, so the write command,
  // grant, assigned and count all become visible together in the WRITE cycle.
  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    src_in_d     = src_in_q;
    en_d         = 1'b0;
    make_entry_d = 1'b0;
    grant_d      = 1'b0;
    reject_d     = 1'b0;
    error_d      = 1'b0;
    gate_open_d  = 1'b0;
    sel_d        = sel_q;
    assigned_d   = assigned_q;
    count_d      = count_q;
    case (state_q)
      IDLE: begin
        if (car_out) begin
          src_in_d = 1'b0;
          if (!E[out_spot]) begin
            state_d = WRITE;
            en_d    = 1'b1;
            sel_d   = out_spot;
            if (count_q != 3'd0) count_d = count_q - 3'd1;
          end else begin
            error_d = 1'b1;
            state_d = HOLD;
          end
        end else if (car_in) begin
          src_in_d = 1'b1;
          if (E != 4'd0) begin
            state_d      = WRITE;
            en_d         = 1'b1;
            make_entry_d = 1'b1;
            grant_d      = 1'b1;
            sel_d        = free_idx;
            assigned_d   = free_idx;
            if (count_q != 3'd4) count_d = count_q + 3'd1;
          end else begin
            reject_d = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      WRITE: begin
        state_d     = GATE;
        gate_cnt_d  = GATE_LOAD;
        gate_open_d = 1'b1;
      end
      GATE: begin
        if (gate_cnt_q <= 8'd1) begin
          state_d    = HOLD;
          gate_cnt_d = 8'd0;
        end else begin
          gate_cnt_d  = gate_cnt_q - 8'd1;
          gate_open_d = 1'b1;
        end
      end
      HOLD: begin
        // Wait for the initiating request to drop so one held level is served once.
        if (src_in_q ? !car_in : !car_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    full_d = (count_d == 3'd4);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      gate_cnt_q   <= 8'd0;
      src_in_q     <= 1'b0;
      en_q         <= 1'b0;
      make_entry_q <= 1'b0;
      sel_q        <= 2'd0;
      assigned_q   <= 2'd0;
      grant_q      <= 1'b0;
      reject_q     <= 1'b0;
      error_q      <= 1'b0;
      gate_open_q  <= 1'b0;
      full_q       <= 1'b0;
      count_q      <= 3'd0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      src_in_q     <= src_in_d;
      en_q         <= en_d;
      make_entry_q <= make_entry_d;
      sel_q        <= sel_d;
      assigned_q   <= assigned_d;
      grant_q      <= grant_d;
      reject_q     <= reject_d;
      error_q      <= error_d;
      gate_open_q  <= gate_open_d;
      full_q       <= full_d;
      count_q      <= count_d;
    end
  end

  assign En         = en_q;
  assign make_entry = make_entry_q;
  assign sel        = sel_q;
  assign assigned   = assigned_q;
  assign grant      = grant_q;
  assign reject     = reject_q;
  assign error      = error_q;
  assign gate_open  = gate_open_q;
  assign full       = full_q;
  assign count      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_spot_allocator.sv
// ---------------------------------------------------------------------------
// tb_spot_allocator : scoreboard bench for spot_allocator with occupancy model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spot_allocator;

  localparam int GATE_CYCLES = 8;
  localparam logic [1:0] K_WRITE  = 2'd0;
  localparam logic [1:0] K_REJECT = 2'd1;
  localparam logic [1:0] K_ERROR  = 2'd2;
  localparam logic [1:0] K_BAD    = 2'd3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       car_in = 1'b0;
  logic       car_out = 1'b0;
  logic [1:0] out_spot = 2'd0;
  logic [3:0] E;
  logic       En, make_entry, grant, reject, error, gate_open, full;
  logic [1:0] sel, assigned;
  logic [2:0] count;

  logic       e_load = 1'b0;
  logic [3:0] e_load_val = 4'hF;
  logic [3:0] e_reg;

  typedef struct packed {
    logic [1:0] kind;
    logic       me;
    logic [1:0] sel;
    logic [1:0] asg;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  spot_allocator #(.GATE_CYCLES(GATE_CYCLES)) dut (
    .CLK(CLK), .RST(RST), .car_in(car_in), .car_out(car_out),
    .out_spot(out_spot), .E(E), .En(En), .make_entry(make_entry),
    .sel(sel), .assigned(assigned), .grant(grant), .reject(reject),
    .error(error), .gate_open(gate_open), .full(full), .count(count)
  );

  always #5 CLK = ~CLK;

  // Occupancy register model: shares RST, reflects a write one cycle after En.
  always @(posedge CLK or negedge RST) begin
    if (!RST)        e_reg <= 4'hF;
    else if (e_load) e_reg <= e_load_val;
    else if (En)     e_reg[sel] <= ~make_entry;
  end
  assign E = e_reg;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] k, input logic me, input logic [1:0] s,
                              input logic [1:0] a);
    exp_t x;
    x.kind = k; x.me = me; x.sel = s; x.asg = a;
    return x;
  endfunction

  task automatic monitor();
    int   run = 0;
    logic prev_en = 1'b0, prev_gate = 1'b0;
    logic [1:0] k;
    exp_t x;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        run = 0; prev_en = 1'b0; prev_gate = 1'b0;
      end else begin
        if (En || reject || error) begin
          k = (En && !reject && !error) ? K_WRITE :
              (reject && !En && !error) ? K_REJECT :
              (error && !En && !reject) ? K_ERROR : K_BAD;
          if (sb.size() == 0) begin
            chk("unexpected_event", {6'd0, k}, 8'hFF);
          end else begin
            x = sb.pop_front();
            chk("event_kind", {6'd0, k}, {6'd0, x.kind});
            if (x.kind == K_WRITE) begin
              chk("make_entry", {7'd0, make_entry}, {7'd0, x.me});
              chk("sel", {6'd0, sel}, {6'd0, x.sel});
              chk("grant", {7'd0, grant}, {7'd0, x.me});
              if (x.me) chk("assigned", {6'd0, assigned}, {6'd0, x.asg});
            end
          end
        end
        if (gate_open && !prev_gate) begin
          chk("gate_after_write", {7'd0, prev_en}, 8'd1);
          run = 1;
        end else if (gate_open) begin
          run++;
        end else if (prev_gate) begin
          chk("gate_len", 8'(run), 8'(GATE_CYCLES));
        end
        prev_en = En;
        prev_gate = gate_open;
      end
    end
  endtask

  task automatic pulse_in();
    @(posedge CLK); #1 car_in = 1'b1;
    @(posedge CLK); #1 car_in = 1'b0;
  endtask

  task automatic pulse_out(input logic [1:0] s);
    @(posedge CLK); #1 out_spot = s; car_out = 1'b1;
    @(posedge CLK); #1 car_out = 1'b0;
  endtask

  task automatic set_e(input logic [3:0] v);
    @(posedge CLK); #1 e_load_val = v; e_load = 1'b1;
    @(posedge CLK); #1 e_load = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (sb.size() == 0 && !gate_open) break;
    end
    if (i == 200) chk("drain_timeout", 8'(sb.size()), 8'd0);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin
    fork monitor(); join_none
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("rst_En", {7'd0, En}, 8'd0);
    chk("rst_gate", {7'd0, gate_open}, 8'd0);
    chk("rst_count", {5'd0, count}, 8'd0);
    chk("rst_full", {7'd0, full}, 8'd0);
    chk("rst_assigned", {6'd0, assigned}, 8'd0);
    chk("rst_pulses", {5'd0, grant, reject, error}, 8'd0);

    // First entry into an empty lot
    sb.push_back(mk(K_WRITE, 1'b1, 2'd0, 2'd0));
    pulse_in(); drain();
    chk("count_1", {5'd0, count}, 8'd1);

    // Held request across a whole grant: exactly one write
    sb.push_back(mk(K_WRITE, 1'b1, 2'd1, 2'd1));
    @(posedge CLK); #1 car_in = 1'b1;
    repeat (40) @(posedge CLK);
    #1 car_in = 1'b0;
    drain();
    chk("count_2", {5'd0, count}, 8'd2);

    // Fill remaining spots
    sb.push_back(mk(K_WRITE, 1'b1, 2'd2, 2'd2));
    pulse_in(); drain();
    sb.push_back(mk(K_WRITE, 1'b1, 2'd3, 2'd3));
    pulse_in(); drain();
    chk("count_full", {5'd0, count}, 8'd4);
    chk("full_flag", {7'd0, full}, 8'd1);

    // Fifth car is rejected
    sb.push_back(mk(K_REJECT, 1'b0, 2'd0, 2'd0));
    pulse_in(); drain();
    chk("count_after_reject", {5'd0, count}, 8'd4);
    chk("assigned_hold", {6'd0, assigned}, 8'd3);

    // Exit naming a free spot, then a valid exit
    set_e(4'b0110);
    sb.push_back(mk(K_ERROR, 1'b0, 2'd0, 2'd0));
    pulse_out(2'd2); drain();
    chk("count_after_error", {5'd0, count}, 8'd4);
    sb.push_back(mk(K_WRITE, 1'b0, 2'd3, 2'd0));
    pulse_out(2'd3); drain();
    chk("count_after_release", {5'd0, count}, 8'd3);
    chk("full_clear", {7'd0, full}, 8'd0);

    // Simultaneous entry and exit: release first, then entry
    set_e(4'b1110);
    sb.push_back(mk(K_WRITE, 1'b0, 2'd0, 2'd0));
    sb.push_back(mk(K_WRITE, 1'b1, 2'd0, 2'd0));
    @(posedge CLK); #1 out_spot = 2'd0; car_in = 1'b1; car_out = 1'b1;
    @(posedge CLK); #1 car_out = 1'b0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge CLK);
    #1 car_in = 1'b0;
    drain();
    chk("count_after_both", {5'd0, count}, 8'd3);

    // Reset during the third gate cycle
    sb.push_back(mk(K_WRITE, 1'b1, 2'd1, 2'd1));
    pulse_in();
    for (int i = 0; i < 20 && !gate_open; i++) begin
      @(posedge CLK); #1;
    end
    chk("gate_seen", {7'd0, gate_open}, 8'd1);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0; car_in = 1'b1;
    #1;
    chk("rst_gate_close", {7'd0, gate_open}, 8'd0);
    chk("rst_count_clear", {5'd0, count}, 8'd0);
    chk("rst_full_clear", {7'd0, full}, 8'd0);
    sb.push_back(mk(K_WRITE, 1'b1, 2'd0, 2'd0));
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 car_in = 1'b0;
    drain();
    chk("count_after_rst", {5'd0, count}, 8'd1);
    chk("sb_empty", 8'(sb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spot_allocator.md
# spot_allocator

Front-end controller that drives the parking spot-occupancy register. It takes entry and exit requests from the gate sensors and reads the 4-bit empty-spot vector. It picks the lowest-numbered free spot for an arriving car and issues the one-cycle write command (En/make_entry/sel) that marks a spot occupied or free. It also sequences the barrier gate, keeps an occupancy count, and flags full, reject and error conditions.

## Interface
- GATE_CYCLES, 8, cycles gate_open stays high after a grant or release; legal range 1..255.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- car_in  input  1  entry request level from the entry sensor; held high while a car waits.
- car_out  input  1  exit request level from the exit sensor.
- out_spot  input  2  spot index being vacated; sampled when car_out is accepted.
- E  input  4  empty-spot vector from the occupancy register; 1 = free.
- En  output  1  register write enable; one-cycle pulse.
- make_entry  output  1  1 = mark spot occupied, 0 = mark free; meaningful only when En=1.
- sel  output  2  spot index for the write; meaningful only when En=1.
- assigned  output  2  spot granted to the last entering car; held until the next grant.
- grant  output  1  one-cycle pulse, coincident with the entry write.
- reject  output  1  one-cycle pulse when an entry is refused because the lot is full.
- error  output  1  one-cycle pulse when an exit names a spot that is already free.
- gate_open  output  1  barrier open command.
- full  output  1  high when count == 4.
- count  output  3  occupied-spot count, 0..4.

## Operation
- States: IDLE, WRITE, GATE, HOLD.
- All outputs are registered. In IDLE all pulses are 0.
- IDLE, car_out=1:
  - If E[out_spot]=0, latch the index and go to WRITE with release type.
  - If E[out_spot]=1, pulse error and go to HOLD. No write, count unchanged.
- IDLE, car_in=1, car_out=0:
  - If E != 0, latch idx = lowest i with E[i]=1 and go to WRITE with entry type.
  - If E == 0, pulse reject and go to HOLD.
- car_out has priority over car_in when both are high in IDLE. The entry is serviced on a later IDLE visit if car_in is still high.
- WRITE lasts exactly one cycle: En=1, sel=idx.
  - Entry: make_entry=1, grant=1, assigned<=idx, count<=count+1.
  - Release: make_entry=0, count<=count-1.
  - Next state is GATE.
- GATE: gate_open=1 for exactly GATE_CYCLES cycles, counted by an internal 8-bit down-counter. Then go to HOLD.
- HOLD: wait until the request that started the transaction is deasserted (car_in for entry/reject, car_out for release/error), then go to IDLE. This prevents one held request from being serviced twice.
- full = (count == 4), updated in the same cycle as count.
- Count saturation is a guard only: never increment past 4 and never decrement below 0. Under correct E these limits are unreachable.
- E is sampled only in IDLE. E reflects a write one cycle after the En pulse, and IDLE is re-entered at least GATE_CYCLES+1 cycles later, so every sample is coherent.

## Timing
- Reset (RST=0, asynchronous): state=IDLE and the gate counter is cleared. Outputs after reset: En=0, make_entry=0, sel=0, assigned=0, grant=0, reject=0, error=0, gate_open=0, count=0, full=0.
- Reset mid-GATE closes the gate immediately. Reset during WRITE aborts the pulse. The occupancy register shares RST and returns to all-free, so count=0 stays consistent.
- Request accepted at edge N (IDLE→WRITE) gives the En/grant pulse during cycle N+1. gate_open is high for cycles N+2 .. N+1+GATE_CYCLES.
- Reject and error pulse in the cycle after the accepting edge, then HOLD.
- Minimum IDLE-to-IDLE turnaround with the request already low: GATE_CYCLES+3 cycles for grant/release, 2 cycles for reject/error.
- Requests arriving outside IDLE are ignored while they are low. A request still high when IDLE is re-entered is serviced then.

## Test plan
- Reset, E=1111, car_in high for 1 cycle then low:
  - En=1, make_entry=1, sel=0, grant=1, assigned=0 in the cycle after acceptance.
  - gate_open high for 8 cycles.
  - count=1, back to IDLE.
- Fill the lot: four entries with E updated by a model register. Required: assigned sequence 0,1,2,3; count=4; full=1. A fifth car_in gives reject=1, no En, and gate_open stays 0.
- E=0110, car_out=1, out_spot=2 (spot 2 free): error=1, no En, count unchanged. Then out_spot=3: En=1, make_entry=0, sel=3, count decrements.
- car_in and car_out rise in the same cycle with E=1110, out_spot=0: release is serviced first (sel=0, make_entry=0). Then, car_in still high, entry is serviced: sel=0, assigned=0.
- car_in held high across a whole grant: exactly one grant. No second write until car_in falls and rises again.
- RST asserted at the 3rd gate_open cycle: gate_open=0 and count=0 immediately, state IDLE. The first edge after release with car_in=1 grants spot 0.
